// File: rtl/ssd_pkg.sv
// Shared types and constants for the two-digit seven-segment scan multiplexer.
// Segment vectors are {a,b,c,d,e,f,g} with bit6=a, all active-low.
package ssd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIG0,
    BLANK0,
    DIG1,
    BLANK1
  } ssd_scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0000001,
    7'b1001111,
    7'b0010010,
    7'b0000110,
    7'b1001100,
    7'b0100100,
    7'b0100000,
    7'b0001111,
    7'b0000000,
    7'b0000100
  };

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

endpackage

// File: rtl/ssd_scan_mux_2digit_bcd_to_ssd.sv
// BCD to active-low seven-segment decoder; codes 10..15 show a dash.
module bcd_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup, dash for anything that is not a decimal digit
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_DIGIT[0];
      4'd1: seg = SEG_DIGIT[1];
      4'd2: seg = SEG_DIGIT[2];
      4'd3: seg = SEG_DIGIT[3];
      4'd4: seg = SEG_DIGIT[4];
      4'd5: seg = SEG_DIGIT[5];
      4'd6: seg = SEG_DIGIT[6];
      4'd7: seg = SEG_DIGIT[7];
      4'd8: seg = SEG_DIGIT[8];
      4'd9: seg = SEG_DIGIT[9];
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/ssd_scan_mux_2digit.sv
// Two-digit scan multiplexer: captures tens/units BCD, latches them into the
// displayed copy only at frame start, and scans them onto one shared
// active-low segment bus with blank slots between digits.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the tens digit when it is 0.
module ssd_scan_mux_2digit
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       En,
  input  logic       Bcd_valid,
  input  logic [3:0] Bcd1,
  input  logic [3:0] Bcd0,
  output logic [6:0] Seg,
  output logic [1:0] An,
  output logic       Frame_tick
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int PW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [PW-1:0] DIG_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

  localparam ssd_scan_state_t AFTER_DIG0 = (BLANK_CYCLES > 0) ? BLANK0 : DIG1;
  localparam ssd_scan_state_t AFTER_DIG1 = (BLANK_CYCLES > 0) ? BLANK1 : DIG0;

  ssd_scan_state_t state, state_next;
  logic [PW-1:0]   cnt, cnt_next;
  logic [3:0]      cap1, cap0;
  logic [3:0]      act1, act0;
  logic            frame_start;
  logic [3:0]      dig_sel;
  logic [6:0]      dec_seg;
  logic [6:0]      seg_next;
  logic [1:0]      an_next;

  // Slot sequencing: dwell counter decides when each slot ends; En low forces idle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = DIG0;
      DIG0:    if (cnt == DIG_LAST)   state_next = AFTER_DIG0;
      BLANK0:  if (cnt == BLANK_LAST) state_next = DIG1;
      DIG1:    if (cnt == DIG_LAST)   state_next = AFTER_DIG1;
      BLANK1:  if (cnt == BLANK_LAST) state_next = DIG0;
      default: state_next = IDLE;
    endcase
    if (!En) state_next = IDLE;

    cnt_next = cnt + 1'b1;
    if ((state_next != state) || (state_next == IDLE)) cnt_next = '0;

    frame_start = (state_next == DIG0) && (state != DIG0);
  end

  // Pick the digit feeding the shared decoder; at frame start act is being reloaded, so use cap
  always_comb begin
    dig_sel = act0;
    if (state_next == DIG0) dig_sel = frame_start ? cap0 : act0;
    else if (state_next == DIG1) dig_sel = act1;
  end

  bcd_to_ssd u_dec (
    .bcd (dig_sel),
    .seg (dec_seg)
  );

  // Pin values for the slot being entered, so outputs move on the same edge as the state
  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = AN_OFF;
    case (state_next)
      DIG0: begin
        seg_next = dec_seg;
        an_next  = AN_UNITS;
      end
      DIG1: begin
        seg_next = dec_seg;
        an_next  = AN_TENS;
`ifdef LEADING_ZERO_BLANK_EN
        if (act1 == 4'd0) seg_next = SEG_BLANK;
`else
        seg_next = dec_seg;
`endif
      end
      default: begin
        seg_next = SEG_BLANK;
        an_next  = AN_OFF;
      end
    endcase
  end

  // State register and in-slot dwell counter
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture register follows the upstream counter whenever it strobes
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cap1 <= 4'd0;
      cap0 <= 4'd0;
    end else if (Bcd_valid) begin
      cap1 <= Bcd1;
      cap0 <= Bcd0;
    end
  end

  // Displayed digits change only at frame start so a frame never mixes old and new values
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      act1 <= 4'd0;
      act0 <= 4'd0;
    end else if (frame_start) begin
      act1 <= cap1;
      act0 <= cap0;
    end
  end

  // Registered pin drivers keep decode glitches off the display
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Seg        <= SEG_BLANK;
      An         <= AN_OFF;
      Frame_tick <= 1'b0;
    end else begin
      Seg        <= seg_next;
      An         <= an_next;
      Frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_ssd_scan_mux_2digit.sv
// Directed bench for ssd_scan_mux_2digit with REFRESH_DIV=4, BLANK_CYCLES=1.
// Build with or without LEADING_ZERO_BLANK_EN; the tens-zero expectation follows it.
module tb_ssd_scan_mux_2digit;

  localparam logic [6:0] S0    = 7'b0000001;
  localparam logic [6:0] S2    = 7'b0010010;
  localparam logic [6:0] S3    = 7'b0000110;
  localparam logic [6:0] S4    = 7'b1001100;
  localparam logic [6:0] S5    = 7'b0100100;
  localparam logic [6:0] S7    = 7'b0001111;
  localparam logic [6:0] S8    = 7'b0000000;
  localparam logic [6:0] S9    = 7'b0000100;
  localparam logic [6:0] SDASH = 7'b1111110;
  localparam logic [6:0] SOFF  = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TENS0 = SOFF;
`else
  localparam logic [6:0] TENS0 = S0;
`endif

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       En = 1'b0;
  logic       Bcd_valid = 1'b0;
  logic [3:0] Bcd1 = 4'd0;
  logic [3:0] Bcd0 = 4'd0;
  logic [6:0] Seg;
  logic [1:0] An;
  logic       Frame_tick;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  ssd_scan_mux_2digit #(
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .En         (En),
    .Bcd_valid  (Bcd_valid),
    .Bcd1       (Bcd1),
    .Bcd0       (Bcd0),
    .Seg        (Seg),
    .An         (An),
    .Frame_tick (Frame_tick)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [3:0] tens, input logic [3:0] units);
    Bcd_valid = valid;
    Bcd1      = tens;
    Bcd0      = units;
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_slot(input string tag, input logic [1:0] an_exp,
                            input logic [6:0] seg_exp, input logic ft_exp);
    check_output($sformatf("%s.an", tag),  {6'd0, An},         {6'd0, an_exp});
    check_output($sformatf("%s.seg", tag), {1'b0, Seg},        {1'b0, seg_exp});
    check_output($sformatf("%s.ft", tag),  {7'd0, Frame_tick}, {7'd0, ft_exp});
  endtask

  // Walks n_pos cycles of a 10-cycle frame starting at its first DIG0 cycle;
  // optionally strobes a new capture at position cap_at.
  task automatic check_frame(input string tag, input logic [6:0] seg_units,
                             input logic [6:0] seg_tens, input int n_pos,
                             input int cap_at, input logic [3:0] new1, input logic [3:0] new0);
    logic [1:0] an_exp;
    logic [6:0] seg_exp;
    for (int pos = 0; pos < n_pos; pos++) begin
      if (pos < 4) begin
        an_exp = 2'b10; seg_exp = seg_units;
      end else if (pos >= 5 && pos < 9) begin
        an_exp = 2'b01; seg_exp = seg_tens;
      end else begin
        an_exp = 2'b11; seg_exp = SOFF;
      end
      check_slot($sformatf("%s.p%0d", tag, pos), an_exp, seg_exp, pos == 0);
      if (pos == cap_at) apply_stimulus(1'b1, new1, new0);
      step();
      Bcd_valid = 1'b0;
    end
  endtask

  initial begin
    $display("[TB] start");
    #1 Rst = 1'b1;
    #1 check_slot("reset", 2'b11, SOFF, 1'b0);
    step();
    step();
    Rst = 1'b0;
    step();
    check_slot("idle_after_reset", 2'b11, SOFF, 1'b0);

    // 47 captured, display enabled
    apply_stimulus(1'b1, 4'd4, 4'd7);
    step();
    Bcd_valid = 1'b0;
    En = 1'b1;
    step();
    check_frame("f1", S7, S4, 10, -1, 4'd0, 4'd0);
    // 25 captured mid-DIG1: this frame still shows 47
    check_frame("f2", S7, S4, 10, 6, 4'd2, 4'd5);
    // 25 shown; illegal units code captured
    check_frame("f3", S5, S2, 10, 3, 4'd2, 4'hC);
    // dash in units; capture on the edge entering DIG0 gets deferred a frame
    check_frame("f4", SDASH, S2, 10, 9, 4'd0, 4'd3);
    check_frame("f5", SDASH, S2, 10, -1, 4'd0, 4'd0);
    // tens zero
    check_frame("f6", S3, TENS0, 10, -1, 4'd0, 4'd0);

    // drop En during DIG1 cycle 2
    check_frame("f7", S3, TENS0, 6, -1, 4'd0, 4'd0);
    check_slot("f7.p6", 2'b01, TENS0, 1'b0);
    En = 1'b0;
    step();
    check_slot("en_off", 2'b11, SOFF, 1'b0);
    apply_stimulus(1'b1, 4'd9, 4'd8);
    step();
    Bcd_valid = 1'b0;
    check_slot("en_off_hold", 2'b11, SOFF, 1'b0);
    En = 1'b1;
    step();
    check_frame("f8", S8, S9, 10, -1, 4'd0, 4'd0);

    // asynchronous reset in DIG1
    check_frame("f9", S8, S9, 7, -1, 4'd0, 4'd0);
    #2 Rst = 1'b1;
    #1 check_slot("rst_async", 2'b11, SOFF, 1'b0);
    #1 Rst = 1'b0;
    step();
    check_slot("post_rst", 2'b10, S0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_scan_mux_2digit.md
Name: ssd_scan_mux_2digit

Overview:
Downstream display stage for the two-digit BCD 00-99 counter. Captures the tens and units BCD digits and time-multiplexes them onto one shared active-low seven-segment bus with per-digit active-low anode enables. Adds anti-ghosting blank slots between digits and tear-free frame-boundary updates. Replaces per-digit dedicated segment buses.

Parameters:
REFRESH_DIV, 50000, cycles each digit is lit per slot; legal values >= 2
BLANK_CYCLES, 2, all-off cycles after each digit slot; 0 removes the blank states

Ports:
Clk  input  1  system clock; all logic on posedge (the counter updates on negedge, so its outputs settle half a cycle before sampling)
Rst  input  1  asynchronous, active-high reset
En  input  1  display enable
Bcd_valid  input  1  capture strobe for Bcd1/Bcd0
Bcd1  input  4  tens digit, BCD
Bcd0  input  4  units digit, BCD
Seg  output  7  segments {a,b,c,d,e,f,g}, bit6=a, active-low
An  output  2  digit enables, active-low; An[0]=units, An[1]=tens
Frame_tick  output  1  one-cycle pulse at each frame start

Behaviour:
- Interface: single clock Clk; Rst asynchronous, active-high.
- Reset values: Seg=7'b1111111, An=2'b11, Frame_tick=0, state=IDLE, prescaler=0, capture and active digit registers=0.
- Capture: Bcd_valid=1 at a posedge loads cap1<=Bcd1 and cap0<=Bcd0. Display never reads cap directly.
- Tear-free update: act1/act0 <= cap1/cap0 only on the edge entering DIG0. A capture mid-frame takes effect at the next frame.
- FSM states: IDLE, DIG0, BLANK0, DIG1, BLANK1.
  - IDLE -> DIG0 when En=1.
  - DIG0 -> BLANK0 after REFRESH_DIV cycles.
  - BLANK0 -> DIG1 after BLANK_CYCLES cycles.
  - DIG1 -> BLANK1 after REFRESH_DIV cycles.
  - BLANK1 -> DIG0 after BLANK_CYCLES cycles.
  - With BLANK_CYCLES=0: DIG0 -> DIG1 -> DIG0 directly.
- Prescaler: counts 0..limit-1 within a state and clears on every state change. Frame length = 2*(REFRESH_DIV+BLANK_CYCLES) cycles.
- En=0 in any state: next edge goes to IDLE, prescaler clears, outputs go all-off. En re-asserted: next edge enters DIG0 with a fresh act load.
- Outputs are registered from the next-state decode, so Seg/An change on the same edge as the state register. No combinational glitches reach the pins.
  - DIG0: An=2'b10, Seg=dec(act0).
  - DIG1: An=2'b01, Seg=dec(act1).
  - IDLE/BLANK*: An=2'b11, Seg=7'b1111111.
- Decoder, digits 0..9:
  - 0: 0000001
  - 1: 1001111
  - 2: 0010010
  - 3: 0000110
  - 4: 1001100
  - 5: 0100100
  - 6: 0100000
  - 7: 0001111
  - 8: 0000000
  - 9: 0000100
  - Illegal codes 10..15: dash 1111110.
- Frame_tick=1 for exactly the one cycle in which the state register holds DIG0's first cycle. This includes entry from IDLE.
- Bcd_valid on the same edge as DIG0 entry: act receives the old cap value. The new value displays from the next frame.
- Rst asserted mid-operation: outputs go to reset values immediately, without waiting for Clk.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in DIG1, if act1==0, Seg=7'b1111111 while An=2'b01 still asserts (slot timing unchanged).
- Undefined: tens zero displays as 0000001.
- The units digit is never blanked.

Decomposition:
- Shared package ssd_pkg holds:
  - state enum ssd_scan_state_t (IDLE, DIG0, BLANK0, DIG1, BLANK1);
  - constants SEG_DIGIT[0:9], SEG_BLANK=7'b1111111, SEG_DASH=7'b1111110;
  - AN_OFF=2'b11.
- One combinational sub-module bcd_to_ssd (4-bit in, 7-bit out, dash default), instantiated once and muxed by state.
- The counter's own decoder migrates to bcd_to_ssd.

Test Plan:
All cases use REFRESH_DIV=4, BLANK_CYCLES=1.
1. Rst pulse asynchronously mid-DIG1 -> Seg=1111111 and An=11 before the next Clk edge; Frame_tick=0.
2. Bcd1=4, Bcd0=7, Bcd_valid pulse, then En=1 -> 4 cycles An=10 Seg=0001111; 1 cycle An=11; 4 cycles An=01 Seg=1001100; 1 blank cycle; Frame_tick period exactly 10 cycles.
3. Bcd1=2, Bcd0=5 captured during DIG1 of a 47 frame -> rest of the frame still shows 4; next frame shows 0100100 then 0010010.
4. Bcd0=4'hC captured -> units slot Seg=1111110; tens unaffected.
5. En dropped during DIG1 cycle 2 -> next edge An=11, Seg=1111111; En raised -> DIG0 entered with Frame_tick=1.
6. Bcd1=0, Bcd0=3 -> with LEADING_ZERO_BLANK_EN, tens slot An=01 Seg=1111111; without it, Seg=0000001; units Seg=0000110 in both builds.
